// File: rtl/encoder16to4_stream.sv
// rtl/encoder16to4_stream.sv - streaming 16-to-4 encoder, one index per beat in priority order
module encoder16to4_stream #(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] D,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  a,
    output logic        last,
    output logic        none,
    output logic [4:0]  count
);

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pending;
    logic        accept;
    logic        beat;
    logic        one_hot;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Later loop iterations win, so the scan direction selects the priority.
    always_comb begin
        a = 4'd0;
        if (LOW_FIRST) begin
            for (int i = 15; i >= 0; i--) begin
                if (pending[i]) a = 4'(i);
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (pending[i]) a = 4'(i);
            end
        end
    end

    assign one_hot   = (pending != 16'd0) && ((pending & (pending - 16'd1)) == 16'd0);
    assign last      = one_hot | none;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == EMIT);
    assign accept    = in_valid & in_ready;
    assign beat      = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EMIT;
            EMIT:    if (beat && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 16'd0;
            count   <= 5'd0;
            none    <= 1'b0;
        end else if (accept) begin
            pending <= D;
            count   <= popcount16(D);
            none    <= (D == 16'd0);
        end else if (beat) begin
            pending <= pending & ~(16'd1 << a);
            if (last) none <= 1'b0;
        end
    end

endmodule

// File: tb/tb_encoder16to4_stream.sv
// tb/tb_encoder16to4_stream.sv - directed self-checking bench for encoder16to4_stream
module tb_encoder16to4_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] D;
    logic        out_ready;
    logic        in_ready_lo, out_valid_lo, last_lo, none_lo;
    logic [3:0]  a_lo;
    logic [4:0]  count_lo;
    logic        in_ready_hi, out_valid_hi, last_hi, none_hi;
    logic [3:0]  a_hi;
    logic [4:0]  count_hi;

    int total = 0;
    int bad   = 0;

    int exp_lo [4] = '{0, 8, 11, 15};
    int exp_hi [4] = '{15, 11, 8, 0};

    always #5 clk = ~clk;

    encoder16to4_stream #(.LOW_FIRST(1'b1)) u_lo (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_lo), .D(D),
        .out_valid(out_valid_lo), .out_ready(out_ready), .a(a_lo), .last(last_lo),
        .none(none_lo), .count(count_lo)
    );

    encoder16to4_stream #(.LOW_FIRST(1'b0)) u_hi (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_hi), .D(D),
        .out_valid(out_valid_hi), .out_ready(out_ready), .a(a_hi), .last(last_hi),
        .none(none_hi), .count(count_hi)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int ea, input logic el,
                            input logic en, input int ec);
        chk({tag, ".valid"}, 16'(out_valid_lo), 16'd1);
        chk({tag, ".ready"}, 16'(in_ready_lo), 16'd0);
        chk({tag, ".a"}, 16'(a_lo), 16'(ea));
        chk({tag, ".last"}, 16'(last_lo), 16'(el));
        chk({tag, ".none"}, 16'(none_lo), 16'(en));
        chk({tag, ".count"}, 16'(count_lo), 16'(ec));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".in_ready"}, 16'(in_ready_lo), 16'd1);
        chk({tag, ".out_valid"}, 16'(out_valid_lo), 16'd0);
        chk({tag, ".a"}, 16'(a_lo), 16'd0);
    endtask

    task automatic accept(input logic [15:0] d);
        in_valid = 1'b1;
        D        = d;
        step();
        in_valid = 1'b0;
        D        = 16'hA5A5;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; D = 16'd0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_idle("reset");
        chk("reset.last", 16'(last_lo), 16'd0);
        chk("reset.none", 16'(none_lo), 16'd0);
        chk("reset.count", 16'(count_lo), 16'd0);

        // reset during emission
        accept(16'h0F00);
        chk_beat("rst_mid.b0", 8, 1'b0, 1'b0, 4);
        chk("rst_mid.hi_a", 16'(a_hi), 16'd11);
        out_ready = 1'b1;
        step();
        chk_beat("rst_mid.b1", 9, 1'b0, 1'b0, 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("rst_mid.after");
        chk("rst_mid.count", 16'(count_lo), 16'd0);
        step();
        chk_idle("rst_mid.quiet");
        accept(16'h0002);
        chk_beat("rst_mid.new", 1, 1'b1, 1'b0, 1);
        step();
        chk_idle("rst_mid.done");

        // ordering, both priorities
        accept(16'h8901);
        for (int i = 0; i < 4; i++) begin
            chk_beat($sformatf("order.b%0d", i), exp_lo[i], (i == 3), 1'b0, 4);
            chk($sformatf("order.hi_a%0d", i), 16'(a_hi), 16'(exp_hi[i]));
            chk($sformatf("order.hi_last%0d", i), 16'(last_hi), 16'(i == 3));
            step();
        end
        chk_idle("order.done");

        // backpressure
        out_ready = 1'b0;
        accept(16'h0030);
        for (int i = 0; i < 3; i++) begin
            chk_beat($sformatf("stall.c%0d", i), 4, 1'b0, 1'b0, 2);
            step();
        end
        out_ready = 1'b1;
        chk_beat("stall.b0", 4, 1'b0, 1'b0, 2);
        step();
        chk_beat("stall.b1", 5, 1'b1, 1'b0, 2);
        step();
        chk_idle("stall.done");

        // zero vector
        accept(16'h0000);
        chk_beat("zero.b0", 0, 1'b1, 1'b1, 0);
        step();
        chk_idle("zero.done");
        chk("zero.none_clr", 16'(none_lo), 16'd0);

        // full vector, both priorities
        accept(16'hFFFF);
        for (int i = 0; i < 16; i++) begin
            chk_beat($sformatf("full.b%0d", i), i, (i == 15), 1'b0, 16);
            chk($sformatf("full.hi_a%0d", i), 16'(a_hi), 16'(15 - i));
            chk($sformatf("full.hi_cnt%0d", i), 16'(count_hi), 16'd16);
            step();
        end
        chk_idle("full.done");
        chk("full.count_held", 16'(count_lo), 16'd16);

        // input ignored while busy
        out_ready = 1'b0;
        accept(16'h0001);
        in_valid = 1'b1; D = 16'hFFFF;
        step();
        chk_beat("busy.c0", 0, 1'b1, 1'b0, 1);
        in_valid = 1'b0;
        step();
        in_valid = 1'b1;
        step();
        chk_beat("busy.c2", 0, 1'b1, 1'b0, 1);
        out_ready = 1'b1;
        step();
        chk_idle("busy.after");
        in_valid = 1'b1; D = 16'h4000;
        step();
        in_valid = 1'b0;
        chk_beat("busy.new", 14, 1'b1, 1'b0, 1);
        chk("busy.hi_a", 16'(a_hi), 16'd14);
        step();
        chk_idle("busy.done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
